frame_codec: RTL and testbench

- Parametrised, registered successor to the power-board link encode/decode logic.
- RX side: accepts tagged frames from the SMPS Arduino link, validates them, and latches measurement fields (V_panel, I_panel, V_cap by default). Flags bad frames and stale data.
- TX side: packs {state, val} into two independently handshaken frames, channel 0 to the SMPS and channel 1 to the ESP32. A frame is sent only when the contents change or a send is requested.

---
 rtl/frame_codec_if.sv | 73 +++++++
 rtl/frame_codec.sv | 190 +++++++++++++++++++
 tb/tb_frame_codec.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_codec_if.sv
// -----------------------------------------------------------------------------
// frame_codec_if
// Bus bundle for frame_codec: the RX measurement link, the controller inputs and
// the two TX frame channels.
//
// Optional feature macro: FRAME_PARITY_EN adds one even-parity LSB to rx_data,
// tx0_data and tx1_data.
//
// Handshake (applies to rx, tx0 and tx1):
//   rx  : valid-only. rx_data is consumed on every clock edge where rx_valid=1;
//         there is no back-pressure.
//   txN : a frame transfers on a clock edge where txN_valid && txN_ready. Once
//         txN_valid rises, txN_data and txN_valid hold until that transfer;
//         valid never depends on ready, and ready may change freely.
//
// Signals (modport slave = the codec side):
//   rx_valid, rx_data          in   measurement frame {field0..fieldN-1, tag[, parity]}
//   fields_out                 out  last good fields, field0 in MSBs
//   rx_update, rx_error        out  one-cycle pulses: good / rejected frame
//   err_count                  out  saturating rejected-frame count
//   stale                      out  no good frame for STALE_CYCLES
//   state, val, tx_kick        in   controller payload and forced-send request
//   tx0_data/valid/ready       SMPS channel
//   tx1_data/valid/ready       ESP32 channel
//   tx_busy                    out  debug: bit n = channel n FSM is in SEND
// -----------------------------------------------------------------------------
interface frame_codec_if #(
   parameter int STATE_W   = 3,
   parameter int VAL_W     = 10,
   parameter int FIELD_W   = 8,
   parameter int RX_FIELDS = 3,
   parameter int RX_TAG_W  = 4,
   parameter int ERR_W     = 8
);
`ifdef FRAME_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int RX_W  = RX_FIELDS * FIELD_W + RX_TAG_W + PB;
   localparam int TX0_W = 4 + STATE_W + VAL_W + 7 + PB;
   localparam int TX1_W = 1 + STATE_W + VAL_W + 2 + PB;

   logic                         rx_valid;
   logic [RX_W-1:0]              rx_data;
   logic [RX_FIELDS*FIELD_W-1:0] fields_out;
   logic                         rx_update;
   logic                         rx_error;
   logic [ERR_W-1:0]             err_count;
   logic                         stale;
   logic [STATE_W-1:0]           state;
   logic [VAL_W-1:0]             val;
   logic                         tx_kick;
   logic [TX0_W-1:0]             tx0_data;
   logic                         tx0_valid;
   logic                         tx0_ready;
   logic [TX1_W-1:0]             tx1_data;
   logic                         tx1_valid;
   logic                         tx1_ready;
   logic [1:0]                   tx_busy;

   modport master (
      output rx_valid, rx_data, state, val, tx_kick, tx0_ready, tx1_ready,
      input  fields_out, rx_update, rx_error, err_count, stale,
             tx0_data, tx0_valid, tx1_data, tx1_valid, tx_busy
   );

   modport slave (
      input  rx_valid, rx_data, state, val, tx_kick, tx0_ready, tx1_ready,
      output fields_out, rx_update, rx_error, err_count, stale,
             tx0_data, tx0_valid, tx1_data, tx1_valid, tx_busy
   );
endinterface

// File: rtl/frame_codec.sv
// -----------------------------------------------------------------------------
// frame_codec
// Registered encode/decode for the power-board links.
//   RX: validates tagged measurement frames, latches the fields, counts rejects
//       and flags stale data.
//   TX: two independent IDLE/SEND channels that emit {hdr, state, val, tag}
//       whenever the payload changes, a kick is requested, or after reset.
//
// Optional feature macro: FRAME_PARITY_EN (even-parity LSB on all frames; RX
// frames with bad parity are rejected).
//
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - frame_codec_if.slave (see interface header for signal list)
// -----------------------------------------------------------------------------
module frame_codec #(
   parameter int                  STATE_W      = 3,
   parameter int                  VAL_W        = 10,
   parameter int                  FIELD_W      = 8,
   parameter int                  RX_FIELDS    = 3,
   parameter int                  RX_TAG_W     = 4,
   parameter logic [RX_TAG_W-1:0] RX_TAG       = 4'b1010,
   parameter logic [3:0]          TX0_HDR      = 4'b1000,
   parameter logic [6:0]          TX0_TAG      = 7'b1100101,
   parameter logic                TX1_HDR      = 1'b1,
   parameter logic [1:0]          TX1_TAG      = 2'b01,
   parameter int                  STALE_CYCLES = 1000000,
   parameter int                  ERR_W        = 8
) (
   input logic          clk,
   input logic          rst,
   frame_codec_if.slave bus
);
`ifdef FRAME_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int FW    = RX_FIELDS * FIELD_W;
   localparam int RX_W  = FW + RX_TAG_W + PB;
   localparam int PW    = STATE_W + VAL_W;
   localparam int TX0_W = 4 + PW + 7 + PB;
   localparam int TX1_W = 1 + PW + 2 + PB;
   localparam int SW    = (STALE_CYCLES > 2) ? $clog2(STALE_CYCLES) : 1;
   localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES - 1);

   typedef enum logic {IDLE, SEND} tx_state_t;

   // ---------------- RX ----------------
   logic [FW-1:0]       rx_fields;
   logic [RX_TAG_W-1:0] rx_tag;
   logic                par_ok, rx_good, rx_bad;
   logic [FW-1:0]       fields_q;
   logic                update_q, error_q, stale_q;
   logic [ERR_W-1:0]    err_q;
   logic [SW-1:0]       stale_cnt, stale_inc;

   assign rx_fields = bus.rx_data[RX_W-1 -: FW];
   assign rx_tag    = bus.rx_data[PB +: RX_TAG_W];
`ifdef FRAME_PARITY_EN
   assign par_ok = ~(^bus.rx_data);
`else
   assign par_ok = 1'b1;
`endif
   assign rx_good   = bus.rx_valid && (rx_tag == RX_TAG) && par_ok;
   assign rx_bad    = bus.rx_valid && !rx_good;
   assign stale_inc = stale_cnt + 1'b1;

   // The stale counter comes out of reset saturated so stale=1 is consistent
   // with the counter until the first good frame arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         fields_q  <= '0;
         update_q  <= 1'b0;
         error_q   <= 1'b0;
         err_q     <= '0;
         stale_cnt <= STALE_MAX;
         stale_q   <= 1'b1;
      end else begin
         update_q <= rx_good;
         error_q  <= rx_bad;
         if (rx_good) fields_q <= rx_fields;
         if (rx_bad && (err_q != '1)) err_q <= err_q + 1'b1;
         if (rx_good) begin
            stale_cnt <= '0;
            stale_q   <= 1'b0;
         end else if (stale_cnt != STALE_MAX) begin
            stale_cnt <= stale_inc;
            stale_q   <= (stale_inc == STALE_MAX);
         end
      end
   end

   // ---------------- TX ----------------
   logic [PW-1:0]      cur;
   logic [TX0_W-PB-1:0] body0;
   logic [TX1_W-PB-1:0] body1;
   logic [TX0_W-1:0]   frame0;
   logic [TX1_W-1:0]   frame1;

   assign cur   = {bus.state, bus.val};
   assign body0 = {TX0_HDR, cur, TX0_TAG};
   assign body1 = {TX1_HDR, cur, TX1_TAG};
`ifdef FRAME_PARITY_EN
   assign frame0 = {body0, ^body0};
   assign frame1 = {body1, ^body1};
`else
   assign frame0 = body0;
   assign frame1 = body1;
`endif

   // Per channel: FSM state, frame register, valid, last-sent payload,
   // kick-pending bit and the post-reset "send once" flag.
   tx_state_t        st0, st0_n, st1, st1_n;
   logic [TX0_W-1:0] data0_q, data0_n;
   logic [TX1_W-1:0] data1_q, data1_n;
   logic             valid0_q, valid0_n, valid1_q, valid1_n;
   logic [PW-1:0]    last0_q, last0_n, last1_q, last1_n;
   logic             pend0_q, pend0_n, pend1_q, pend1_n;
   logic             arm0_q, arm0_n, arm1_q, arm1_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         st0 <= IDLE;  data0_q <= '0;  valid0_q <= 1'b0;
         last0_q <= '0; pend0_q <= 1'b0; arm0_q <= 1'b1;
         st1 <= IDLE;  data1_q <= '0;  valid1_q <= 1'b0;
         last1_q <= '0; pend1_q <= 1'b0; arm1_q <= 1'b1;
      end else begin
         st0 <= st0_n;  data0_q <= data0_n;  valid0_q <= valid0_n;
         last0_q <= last0_n; pend0_q <= pend0_n; arm0_q <= arm0_n;
         st1 <= st1_n;  data1_q <= data1_n;  valid1_q <= valid1_n;
         last1_q <= last1_n; pend1_q <= pend1_n; arm1_q <= arm1_n;
      end
   end

   // Channel 0 (SMPS). A kick seen during SEND is parked in pend0 so it
   // produces exactly one extra frame once the channel returns to IDLE.
   always_comb begin
      st0_n = st0; data0_n = data0_q; valid0_n = valid0_q;
      last0_n = last0_q; pend0_n = pend0_q; arm0_n = arm0_q;
      case (st0)
         IDLE: begin
            if ((cur != last0_q) || bus.tx_kick || pend0_q || arm0_q) begin
               data0_n = frame0; last0_n = cur; valid0_n = 1'b1;
               pend0_n = 1'b0;   arm0_n = 1'b0; st0_n = SEND;
            end
         end
         SEND: begin
            if (bus.tx_kick) pend0_n = 1'b1;
            if (valid0_q && bus.tx0_ready) begin
               valid0_n = 1'b0; st0_n = IDLE;
            end
         end
         default: st0_n = IDLE;
      endcase
   end

   // Channel 1 (ESP32), same behaviour, independent of channel 0.
   always_comb begin
      st1_n = st1; data1_n = data1_q; valid1_n = valid1_q;
      last1_n = last1_q; pend1_n = pend1_q; arm1_n = arm1_q;
      case (st1)
         IDLE: begin
            if ((cur != last1_q) || bus.tx_kick || pend1_q || arm1_q) begin
               data1_n = frame1; last1_n = cur; valid1_n = 1'b1;
               pend1_n = 1'b0;   arm1_n = 1'b0; st1_n = SEND;
            end
         end
         SEND: begin
            if (bus.tx_kick) pend1_n = 1'b1;
            if (valid1_q && bus.tx1_ready) begin
               valid1_n = 1'b0; st1_n = IDLE;
            end
         end
         default: st1_n = IDLE;
      endcase
   end

   assign bus.fields_out = fields_q;
   assign bus.rx_update  = update_q;
   assign bus.rx_error   = error_q;
   assign bus.err_count  = err_q;
   assign bus.stale      = stale_q;
   assign bus.tx0_data   = data0_q;
   assign bus.tx0_valid  = valid0_q;
   assign bus.tx1_data   = data1_q;
   assign bus.tx1_valid  = valid1_q;
   assign bus.tx_busy    = {st1 == SEND, st0 == SEND};
endmodule

// File: tb/tb_frame_codec.sv
// -----------------------------------------------------------------------------
// tb_frame_codec
// Self-checking bench for frame_codec. A behavioural model (cycles-since-good
// counter, saturating reject count, per-channel frame queues) predicts every
// output after each clock edge. Build with or without FRAME_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_frame_codec;
   localparam int STALE = 16;
`ifdef FRAME_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int RX_W  = 28 + PB;
   localparam int TX0_W = 24 + PB;
   localparam int TX1_W = 16 + PB;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   frame_codec_if #(.STATE_W(3), .VAL_W(10), .FIELD_W(8), .RX_FIELDS(3),
                    .RX_TAG_W(4), .ERR_W(8)) bus ();

   frame_codec #(.STALE_CYCLES(STALE)) dut (.clk(clk), .rst(rst), .bus(bus));

   // ---------------- scoreboard state ----------------
   int vectors = 0;
   int miscompares = 0;
   int hs0 = 0, hs1 = 0;

   logic [23:0]      m_fields;
   bit               m_upd, m_errp, m_stale;
   int               m_errc, m_since;
   bit               m_busy[2], m_pend[2], m_arm[2];
   logic [12:0]      m_last[2];
   logic [TX0_W-1:0] exp0_q[$];
   logic [TX1_W-1:0] exp1_q[$];
   logic [TX0_W-1:0] m_shown0;
   logic [TX1_W-1:0] m_shown1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- frame builders ----------------
   function automatic logic [TX0_W-1:0] tx0_frame(input logic [12:0] sv);
      logic [23:0] b;
      b = {4'b1000, sv, 7'b1100101};
`ifdef FRAME_PARITY_EN
      return {b, 1'($countones(b) % 2)};
`else
      return b;
`endif
   endfunction

   function automatic logic [TX1_W-1:0] tx1_frame(input logic [12:0] sv);
      logic [15:0] b;
      b = {1'b1, sv, 2'b01};
`ifdef FRAME_PARITY_EN
      return {b, 1'($countones(b) % 2)};
`else
      return b;
`endif
   endfunction

   function automatic logic [RX_W-1:0] rx_frame(input logic [23:0] f, input logic [3:0] tag,
                                                input bit flip);
      logic [27:0] b;
      b = {f, tag};
`ifdef FRAME_PARITY_EN
      return {b, 1'($countones(b) % 2) ^ flip};
`else
      if (flip) return b;
      return b;
`endif
   endfunction

   // ---------------- reference model ----------------
   task automatic model_tx(input int ch, input bit ready);
      logic [12:0] cur;
      cur = {bus.state, bus.val};
      if (m_busy[ch]) begin
         if (bus.tx_kick) m_pend[ch] = 1'b1;
         if (ready) begin
            m_busy[ch] = 1'b0;
            if (ch == 0) m_shown0 = exp0_q.pop_front();
            else         m_shown1 = exp1_q.pop_front();
         end
      end else if (cur != m_last[ch] || bus.tx_kick || m_pend[ch] || m_arm[ch]) begin
         if (ch == 0) exp0_q.push_back(tx0_frame(cur));
         else         exp1_q.push_back(tx1_frame(cur));
         m_last[ch] = cur;
         m_busy[ch] = 1'b1;
         m_pend[ch] = 1'b0;
         m_arm[ch]  = 1'b0;
      end
   endtask

   task automatic model_step();
      bit good;
      if (rst) begin
         m_fields = '0; m_upd = 0; m_errp = 0; m_errc = 0;
         m_since = STALE - 1; m_stale = 1;
         for (int c = 0; c < 2; c++) begin
            m_busy[c] = 0; m_pend[c] = 0; m_arm[c] = 1; m_last[c] = '0;
         end
         exp0_q.delete(); exp1_q.delete();
         m_shown0 = '0; m_shown1 = '0;
      end else begin
         good = bus.rx_valid && (bus.rx_data[PB +: 4] == 4'b1010)
                && (PB == 0 || ($countones(bus.rx_data) % 2) == 0);
         m_upd  = good;
         m_errp = bus.rx_valid && !good;
         if (good) m_fields = bus.rx_data[RX_W-1 -: 24];
         if (m_errp && m_errc < 255) m_errc++;
         if (good) m_since = 0;
         else if (m_since < STALE - 1) m_since++;
         m_stale = (m_since == STALE - 1);
         model_tx(0, bus.tx0_ready);
         model_tx(1, bus.tx1_ready);
      end
   endtask

   task automatic compare();
      check("fields", bus.fields_out, m_fields);
      check("rx_update", bus.rx_update, m_upd);
      check("rx_error", bus.rx_error, m_errp);
      check("err_count", bus.err_count, m_errc);
      check("stale", bus.stale, m_stale);
      check("tx0_valid", bus.tx0_valid, m_busy[0]);
      check("tx1_valid", bus.tx1_valid, m_busy[1]);
      check("tx0_data", bus.tx0_data, m_busy[0] ? exp0_q[0] : m_shown0);
      check("tx1_data", bus.tx1_data, m_busy[1] ? exp1_q[0] : m_shown1);
   endtask

   // ---------------- driver ----------------
   task automatic step();
      if (!rst && bus.tx0_valid && bus.tx0_ready) hs0++;
      if (!rst && bus.tx1_valid && bus.tx1_ready) hs1++;
      @(posedge clk);
      #1;
      model_step();
      compare();
   endtask

   task automatic drive_rx(input bit v, input logic [23:0] f, input logic [3:0] tag, input bit flip);
      bus.rx_valid = v;
      bus.rx_data  = rx_frame(f, tag, flip);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus.rx_valid = 0; bus.rx_data = '0; bus.state = '0; bus.val = '0;
      bus.tx_kick = 0; bus.tx0_ready = 0; bus.tx1_ready = 0;
      rst = 1;
      step(); step();
      check("rst_stale", bus.stale, 1);
      check("rst_tx0_valid", bus.tx0_valid, 0);
      check("rst_tx1_data", bus.tx1_data, 0);

      // one send per channel after reset
      bus.state = 3'b101; bus.val = 10'h2A5;
      bus.tx0_ready = 1; bus.tx1_ready = 1;
      rst = 0; hs0 = 0; hs1 = 0;
      repeat (4) step();
      check("a_tx0", bus.tx0_data, tx0_frame({3'b101, 10'h2A5}));
      check("a_tx0_raw", bus.tx0_data[TX0_W-1 -: 24], 24'({4'b1000, 3'b101, 10'h2A5, 7'b1100101}));
      check("a_tx1_raw", bus.tx1_data[TX1_W-1 -: 16], 16'({1'b1, 3'b101, 10'h2A5, 2'b01}));
      check("a_hs0", hs0, 1);
      check("a_hs1", hs1, 1);

      // good RX frame
      drive_rx(1, 24'h7F12C3, 4'b1010, 0);
      step();
      drive_rx(0, 24'h0, 4'b0, 0);
      check("b_fields", bus.fields_out, 24'h7F12C3);
      check("b_update", bus.rx_update, 1);
      check("b_stale", bus.stale, 0);
      check("b_errc", bus.err_count, 0);
      step();

      // bad tag, then saturation of the reject counter
      drive_rx(1, 24'h7F12C3, 4'b1011, 0);
      step();
      check("c_error", bus.rx_error, 1);
      check("c_errc1", bus.err_count, 1);
      check("c_fields", bus.fields_out, 24'h7F12C3);
      repeat (260) step();
      drive_rx(0, 24'h0, 4'b0, 0);
      step();
      check("c_errc_sat", bus.err_count, 8'hFF);

      // stalled tx0 while val changes twice; tx1 keeps running
      hs0 = 0; hs1 = 0;
      bus.tx0_ready = 0;
      bus.val = 10'h155;
      step();
      bus.val = 10'h0AA;
      repeat (6) step();
      check("d_tx0_hold", bus.tx0_data, tx0_frame({3'b101, 10'h155}));
      check("d_hs1", hs1, 2);
      check("d_tx1_latest", bus.tx1_data, tx1_frame({3'b101, 10'h0AA}));
      bus.tx0_ready = 1;
      repeat (5) step();
      check("d_tx0_latest", bus.tx0_data, tx0_frame({3'b101, 10'h0AA}));
      check("d_hs0", hs0, 2);

      // stale timing: rises exactly 15 cycles after the clearing frame
      drive_rx(1, 24'hA5A5A5, 4'b1010, 0);
      step();
      drive_rx(0, 24'h0, 4'b0, 0);
      for (int i = 1; i <= 15; i++) begin
         step();
         check("e_stale_ramp", bus.stale, (i == 15) ? 1 : 0);
      end
      // good frame arriving in the saturation cycle keeps stale low
      drive_rx(1, 24'h010203, 4'b1010, 0);
      step();
      drive_rx(0, 24'h0, 4'b0, 0);
      repeat (14) step();
      drive_rx(1, 24'h040506, 4'b1010, 0);
      step();
      drive_rx(0, 24'h0, 4'b0, 0);
      check("e_sat_stale", bus.stale, 0);
      check("e_sat_fields", bus.fields_out, 24'h040506);

`ifdef FRAME_PARITY_EN
      drive_rx(1, 24'h7F12C3, 4'b1010, 1);
      step();
      drive_rx(0, 24'h0, 4'b0, 0);
      check("p_reject", bus.rx_error, 1);
      check("p_fields", bus.fields_out, 24'h040506);
`endif

      // kick during SEND triggers exactly one further send
      hs0 = 0;
      bus.tx0_ready = 0;
      bus.tx_kick = 1;
      step();
      step();
      bus.tx_kick = 0;
      repeat (3) step();
      bus.tx0_ready = 1;
      repeat (8) step();
      check("k_hs0", hs0, 2);

      // randomized traffic, including occasional mid-operation resets
      for (int n = 0; n < 2000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         drive_rx(1'($urandom_range(0, 1)), 24'($urandom),
                  ($urandom_range(0, 9) < 7) ? 4'b1010 : 4'($urandom),
                  (PB == 1) && ($urandom_range(0, 4) == 0));
         if ($urandom_range(0, 7) == 0) begin
            bus.state = 3'($urandom);
            bus.val   = 10'($urandom);
         end
         bus.tx_kick   = ($urandom_range(0, 15) == 0);
         bus.tx0_ready = ($urandom_range(0, 3) != 0);
         bus.tx1_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      // quiesce: both channels drain and go idle
      rst = 0; bus.tx_kick = 0; bus.tx0_ready = 1; bus.tx1_ready = 1;
      drive_rx(0, 24'h0, 4'b0, 0);
      repeat (10) step();
      check("q_tx0_idle", bus.tx0_valid, 0);
      check("q_tx1_idle", bus.tx1_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
